// File: rtl/prbs_ber_monitor_pkg.sv
// prbs_ber_monitor_pkg: default link-test parameters and checker state encoding
package prbs_ber_monitor_pkg;
    localparam int DEF_ORDER       = 7;
    localparam int DEF_TAP         = 6;
    localparam int DEF_LOCK_GOOD   = 16;
    localparam int DEF_LOSS_THRESH = 64;
    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/prbs_ber_monitor_prbs_gen.sv
// prbs_ber_monitor_prbs_gen: Fibonacci LFSR with per-bit enable and single-bit error injection
module prbs_ber_monitor_prbs_gen
    import prbs_ber_monitor_pkg::*;
#(
    parameter int ORDER = DEF_ORDER,
    parameter int TAP   = DEF_TAP
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic inject,
    output logic bit_out
);
    logic [ORDER-1:0] s;
    logic fb;
    assign fb = s[ORDER-1] ^ s[TAP-1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s       <= '1;
            bit_out <= 1'b0;
        end else if (en) begin
            s       <= {s[ORDER-2:0], fb};
            bit_out <= fb ^ inject;
        end
    end
endmodule

// File: rtl/prbs_ber_monitor.sv
// prbs_ber_monitor: PRBS source plus self-synchronising checker with windowed error
// counting, flywheel lock and loss-of-lock detection
module prbs_ber_monitor
    import prbs_ber_monitor_pkg::*;
#(
    parameter int PRBS_ORDER  = DEF_ORDER,
    parameter int PRBS_TAP    = DEF_TAP,
    parameter int LOCK_GOOD   = DEF_LOCK_GOOD,
    parameter int WINDOW_LOG2 = 10,
    parameter int LOSS_THRESH = DEF_LOSS_THRESH,
    parameter int TOT_W       = 32
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   tx_en,
    input  logic                   err_inject,
    output logic                   prbs_out,
    input  logic                   rx_en,
    input  logic                   rx_bit,
    input  logic                   clear,
    output logic                   locked,
    output logic                   window_done,
    output logic [WINDOW_LOG2:0]   window_errs,
    output logic [TOT_W-1:0]       total_errs
);
    localparam int FW = $clog2(PRBS_ORDER + 1);
    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int AW = WINDOW_LOG2 + 1;

    logic [PRBS_ORDER-1:0]  r;
    logic [FW-1:0]          fill;
    logic [GW-1:0]          good;
    logic [WINDOW_LOG2-1:0] bit_cnt;
    logic [AW-1:0]          acc, acc_nxt;
    state_t                 state;
    logic                   pred, err, count, wrap;

    prbs_ber_monitor_prbs_gen #(.ORDER(PRBS_ORDER), .TAP(PRBS_TAP)) u_prbs_gen (
        .clk(sys_clk), .rst(reset), .en(tx_en), .inject(err_inject), .bit_out(prbs_out)
    );

    assign pred    = r[PRBS_ORDER-1] ^ r[PRBS_TAP-1];
    assign err     = rx_bit != pred;
    assign count   = rx_en && state == LOCKED && !clear;
    assign wrap    = count && &bit_cnt;
    assign acc_nxt = acc + {{WINDOW_LOG2{1'b0}}, err};
    assign locked  = state == LOCKED;

    // acc and bit_cnt are always zero while searching, so entering lock starts a clean window
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r           <= '0;
            fill        <= '0;
            good        <= '0;
            bit_cnt     <= '0;
            acc         <= '0;
            state       <= SEARCH;
            window_done <= 1'b0;
            window_errs <= '0;
            total_errs  <= '0;
        end else begin
            window_done <= wrap;
            if (rx_en && state == SEARCH) begin
                r <= {r[PRBS_ORDER-2:0], rx_bit};
                if (fill < FW'(PRBS_ORDER)) fill <= fill + 1'b1;
                else if (err) good <= '0;
                else begin
                    good <= good + 1'b1;
                    if (good == GW'(LOCK_GOOD - 1)) state <= LOCKED;
                end
            end else if (rx_en) begin
                r <= {r[PRBS_ORDER-2:0], pred};
                if (wrap && acc_nxt > AW'(LOSS_THRESH)) begin
                    state <= SEARCH;
                    fill  <= '0;
                    good  <= '0;
                end
            end
            if (clear) begin
                acc         <= '0;
                bit_cnt     <= '0;
                window_errs <= '0;
                total_errs  <= '0;
            end else if (count) begin
                bit_cnt <= bit_cnt + 1'b1;
                acc     <= wrap ? '0 : acc_nxt;
                if (wrap) window_errs <= acc_nxt;
                if (err && !(&total_errs)) total_errs <= total_errs + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prbs_ber_monitor.sv
// tb_prbs_ber_monitor: table vectors, directed link scenarios and randomized traffic
// checked every cycle against a sequence-level reference model
module tb_prbs_ber_monitor;
    localparam int ORD = 7, TAP = 6, LG = 16, WL = 10, LT = 64, TW = 8;
    localparam int WIN  = 1 << WL;
    localparam int PER  = (1 << ORD) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic sys_clk = 0, reset = 1, tx_en = 0, err_inject = 0, rx_en = 0, rx_bit = 0, clear = 0;
    logic prbs_out, locked, window_done;
    logic [WL:0] window_errs;
    logic [TW-1:0] total_errs;

    prbs_ber_monitor #(.PRBS_ORDER(ORD), .PRBS_TAP(TAP), .LOCK_GOOD(LG), .WINDOW_LOG2(WL),
                       .LOSS_THRESH(LT), .TOT_W(TW)) dut (
        .sys_clk(sys_clk), .reset(reset), .tx_en(tx_en), .err_inject(err_inject),
        .prbs_out(prbs_out), .rx_en(rx_en), .rx_bit(rx_bit), .clear(clear), .locked(locked),
        .window_done(window_done), .window_errs(window_errs), .total_errs(total_errs)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0, errors = 0;
    int x [PER+ORD];
    int seq [PER];
    int rec [2*PER];
    int hist[$];
    int tx_idx, m_out, fill, good, m_lock, nbits, acc, m_werr, m_tot, m_wdone;
    int mode, tx_pct, inj_pct, inj_req, clr_pml;
    logic prev_tx;

    typedef struct packed {logic tx; logic inj; logic exp;} vec_t;
    vec_t tv [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        tx_idx = 0; m_out = 0; fill = 0; good = 0; m_lock = 0;
        nbits = 0; acc = 0; m_werr = 0; m_tot = 0; m_wdone = 0;
        hist.delete();
        repeat (ORD) hist.push_back(0);
    endtask

    // Checker reference: hist holds the last ORD reference bits, oldest first
    task automatic model_step();
        int pred, e;
        m_wdone = 0;
        if (rx_en) begin
            pred = hist[0] ^ hist[ORD-TAP];
            if (m_lock == 0) begin
                if (fill < ORD) fill++;
                else if (int'(rx_bit) == pred) begin
                    good++;
                    if (good == LG) m_lock = 1;
                end else good = 0;
                hist.push_back(int'(rx_bit));
            end else begin
                e = (int'(rx_bit) != pred) ? 1 : 0;
                hist.push_back(pred);
                if (!clear) begin
                    acc += e;
                    nbits++;
                    if (e == 1 && m_tot < TMAX) m_tot++;
                    if (nbits == WIN) begin
                        m_werr = acc;
                        m_wdone = 1;
                        if (acc > LT) begin m_lock = 0; fill = 0; good = 0; end
                        acc = 0;
                        nbits = 0;
                    end
                end
            end
            void'(hist.pop_front());
        end
        if (clear) begin acc = 0; nbits = 0; m_werr = 0; m_tot = 0; end
        if (tx_en) begin
            m_out = seq[tx_idx % PER] ^ int'(err_inject);
            tx_idx++;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        if (reset) mreset(); else model_step();
        #1;
        chk("prbs_out", int'(prbs_out), m_out);
        chk("locked", int'(locked), m_lock);
        chk("window_done", int'(window_done), m_wdone);
        chk("window_errs", int'(window_errs), m_werr);
        chk("total_errs", int'(total_errs), m_tot);
    endtask

    // mode 0: loopback, 1: rx forced 0, 2: random rx, 3: rx idle
    task automatic drive();
        prev_tx = tx_en;
        tx_en = $urandom_range(99) < tx_pct;
        err_inject = 0;
        if (tx_en && inj_req > 0) begin err_inject = 1; inj_req--; end
        else if ($urandom_range(99) < inj_pct) err_inject = 1;
        clear = $urandom_range(999) < clr_pml;
        rx_en  = mode == 2 ? 1'($urandom) : mode == 3 ? 1'b0 : prev_tx;
        rx_bit = mode == 0 ? 1'(m_out) : mode == 2 ? 1'($urandom) : 1'b0;
    endtask

    task automatic step();
        drive();
        tick();
    endtask

    task automatic do_reset();
        tx_en = 0; err_inject = 0; rx_en = 0; rx_bit = 0; clear = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic run_until_done(input int limit);
        int ok;
        ok = 0;
        for (int i = 0; i < limit && ok == 0; i++) begin
            step();
            if (window_done) ok = 1;
        end
        chk("window_done_seen", ok, 1);
    endtask

    task automatic strobes_to_lock(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit && !locked; i++) begin
            step();
            if (rx_en) n++;
        end
    endtask

    initial begin
        int n, ones, mism, in_range;
        for (int i = 0; i < ORD; i++) x[i] = 1;
        for (int i = 0; i < PER; i++) begin
            x[i+ORD] = x[i] ^ x[i+ORD-TAP];
            seq[i] = x[i+ORD];
        end
        mode = 3; tx_pct = 0; inj_pct = 0; inj_req = 0; clr_pml = 0; prev_tx = 0;
        do_reset();

        // generator vectors: {tx_en, err_inject, expected prbs_out}
        tv = '{3'b100, 3'b000, 3'b111, 3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b101, 3'b111};
        for (int i = 0; i < 10; i++) begin
            tx_en = tv[i].tx; err_inject = tv[i].inj; rx_en = 0; clear = 0;
            tick();
            chk($sformatf("tbl_prbs[%0d]", i), int'(prbs_out), int'(tv[i].exp));
        end

        // free-running period and balance
        do_reset();
        mode = 3; tx_pct = 100;
        for (int k = 0; k < 2*PER; k++) begin
            step();
            rec[k] = int'(prbs_out);
        end
        for (int k = 0; k < ORD; k++) chk($sformatf("first_bit[%0d]", k), rec[k], k == ORD-1 ? 1 : 0);
        ones = 0; mism = 0;
        for (int k = 0; k < PER; k++) begin
            ones += rec[k];
            if (rec[k] != rec[k+PER]) mism++;
        end
        chk("ones_per_period", ones, 64);
        chk("period_mismatches", mism, 0);

        // loopback lock and clean windows
        do_reset();
        mode = 0; tx_pct = 100;
        strobes_to_lock(200, n);
        chk("lock_strobes", n, ORD + LG);
        chk("locked_after_fill", int'(locked), 1);
        run_until_done(1200);
        run_until_done(1200);
        chk("clean_window_errs", int'(window_errs), 0);
        chk("clean_total", int'(total_errs), 0);

        // single injected error
        inj_req = 1;
        run_until_done(1200);
        chk("inject_window_errs", int'(window_errs), 1);
        chk("inject_total", int'(total_errs), 1);
        chk("inject_locked", int'(locked), 1);

        // a full window of forced zeros drops lock at the window end
        mode = 1;
        run_until_done(1200);
        in_range = (window_errs >= 512 && window_errs <= 520) ? 1 : 0;
        chk("forced_window_range", in_range, 1);
        chk("forced_unlock", int'(locked), 0);
        chk("total_saturated", int'(total_errs), TMAX);
        mode = 0;
        strobes_to_lock(200, n);
        chk("relock_strobes", n, ORD + LG);

        // clear mid-window after 5 errors
        run_until_done(1200);
        inj_req = 5;
        repeat (200) step();
        drive();
        clear = 1;
        tick();
        chk("clear_window_errs", int'(window_errs), 0);
        chk("clear_total", int'(total_errs), 0);
        chk("clear_locked", int'(locked), 1);
        inj_req = 2;
        run_until_done(1200);
        chk("post_clear_window_errs", int'(window_errs), 2);
        chk("post_clear_total", int'(total_errs), 2);

        // asynchronous reset mid-window while locked
        repeat (300) step();
        chk("pre_reset_locked", int'(locked), 1);
        #2;
        reset = 1;
        #1;
        chk("rst_prbs_out", int'(prbs_out), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_window_done", int'(window_done), 0);
        chk("rst_window_errs", int'(window_errs), 0);
        chk("rst_total", int'(total_errs), 0);
        tx_en = 0; rx_en = 0; clear = 0; err_inject = 0;
        tick();
        reset = 0;

        // randomized traffic
        mode = 2; tx_pct = 70; inj_pct = 10; clr_pml = 2;
        repeat (3000) step();
        mode = 0; tx_pct = 90; inj_pct = 4; clr_pml = 1;
        repeat (4000) step();
        inj_pct = 9;
        repeat (5000) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prbs_ber_monitor.md
Name: prbs_ber_monitor

Overview:
- Parametrised PRBS link tester: a PRBS source for the transmit chain and a self-synchronising checker on the decoder output.
- Measures errors over fixed bit windows and tracks lock and loss of lock.
- Adds error injection, windowed BER and lock detection to the fixed m-sequence/BER path.
- Runs on one clock. Bit timing comes from per-bit enable strobes, not derived clocks.

Parameters:
PRBS_ORDER, 7, LFSR length; polynomial x^ORDER + x^TAP + 1
PRBS_TAP, 6, second feedback tap (1..ORDER-1)
LOCK_GOOD, 16, consecutive correct predictions required to declare lock
WINDOW_LOG2, 10, measurement window = 2^WINDOW_LOG2 checked bits
LOSS_THRESH, 64, window error count above which lock is dropped
TOT_W, 32, width of the cumulative error counter

Ports:
sys_clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
tx_en  in  1  one-cycle strobe: advance generator, emit next bit
err_inject  in  1  sampled with tx_en; inverts the emitted bit
prbs_out  out  1  registered PRBS bit to the encoder
rx_en  in  1  one-cycle strobe: rx_bit is valid
rx_bit  in  1  received (decoded) bit
clear  in  1  synchronous clear of error statistics
locked  out  1  checker locked
window_done  out  1  one-cycle pulse when a window completes
window_errs  out  WINDOW_LOG2+1  error count of last completed window
total_errs  out  TOT_W  saturating cumulative error count while locked

Behaviour:
- Reset (async): gen state all ones; prbs_out=0; rx shift register 0; locked=0; window_done=0; window_errs=0; total_errs=0; FSM=SEARCH; fill/good/bit/acc counters 0.
- Generator (Fibonacci): fb = s[ORDER-1]^s[TAP-1]; on tx_en: s <= {s[ORDER-2:0], fb}; prbs_out <= fb ^ err_inject. Without tx_en, hold. Period 2^ORDER-1.
- Checker register r[0] is the newest bit. pred = r[ORDER-1]^r[TAP-1]. All actions below occur only on rx_en.
- SEARCH:
  - While fill < ORDER: shift rx_bit into r; fill++.
  - Otherwise: if rx_bit==pred then good++, else good=0. Shift rx_bit into r.
  - When a match brings good to LOCK_GOOD: go to LOCKED, locked=1, bit/acc counters cleared.
- LOCKED (flywheel):
  - Shift pred (not rx_bit) into r.
  - err = rx_bit != pred. acc += err; total_errs += err, saturating at all ones. bit++.
- Window end (bit count wraps 2^WINDOW_LOG2-1 -> 0):
  - window_errs <= acc+err; window_done=1 for one cycle; acc=0.
  - If acc+err > LOSS_THRESH: go to SEARCH, locked=0, fill=0, good=0.
- Latency: locked rises on the cycle after the (ORDER+LOCK_GOOD)-th rx_en of an error-free stream. window_done rises the cycle after the last bit of the window.
- clear: zeros acc, bit count, window_errs, total_errs. FSM, r and the generator are unaffected. If clear coincides with rx_en, r/FSM update normally, but that bit is not counted and no window_done fires.
- tx and rx paths are independent; simultaneous tx_en and rx_en are legal.
- Reset mid-operation: immediate return to reset values; no pulse is emitted.
- acc width WINDOW_LOG2+1 cannot overflow (max 2^WINDOW_LOG2).

Decomposition:
- Shared package: default PRBS_ORDER/PRBS_TAP constants, FSM state enum {SEARCH, LOCKED}, LOCK_GOOD/LOSS_THRESH defaults.
- Sub-module prbs_gen: parametrised LFSR with enable and inject. The checker keeps its own register because its load source is muxed.

Test Plan:
- Reset, tx_en held 1 for 254 cycles -> prbs_out first 7 bits 0,0,0,0,0,0,1; sequence repeats with period 127; 64 ones per period.
- Loopback prbs_out->rx_bit, rx_en=tx_en delayed 1 cycle -> locked=1 after 23 rx_en strobes; every window_done reports window_errs=0; total_errs=0.
- Locked loopback, err_inject=1 on one tx_en -> next window_errs=1; total_errs=1; locked stays 1.
- Locked, rx_bit forced 0 for a full window -> window_errs in 512..520 (>64); locked drops the cycle after window_done. Restoring loopback relocks after 23 strobes.
- Locked with 5 injected errors, clear mid-window -> window_errs and total_errs read 0. The next window counts only post-clear errors. locked is unchanged.
- Assert reset while locked and mid-window -> all outputs return to reset values immediately; no window_done pulse.
